vector_alu_sequencer: RTL and testbench

Multi-cycle controller that executes one 256-bit vector operation (16 lanes × 16 bits) on a narrower lane-ALU array of `PAR` lanes by folding the vector into `16/PAR` beats. It sits between the execute stage and a shared bank of `alus` lane instances. It latches operands and opcode through a valid/ready handshake, drives one slice of lanes to the ALU per cycle, and reassembles the 256-bit result and 64-bit flag vector. It presents them through an output valid/ready handshake. This lets area-constrained builds trade throughput for ALU count without changing the vector ISA.

---
 rtl/vector_alu_sequencer.sv | 116 +++++++++++
 tb/tb_vector_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: folds a 16-lane x 16-bit vector op onto PAR lane ALUs.
// Operands and opcode are latched at accept; results reassemble beat by beat.
module vector_alu_sequencer #(
  parameter int LANE_W = 16,
  parameter int PAR    = 4,
  parameter int BEATS  = 16 / PAR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [255:0]          in_a,
  input  logic [255:0]          in_b,
  input  logic [2:0]            in_ctrl,
  input  logic                  in_sel,
  output logic [PAR*LANE_W-1:0] alu_a,
  output logic [PAR*LANE_W-1:0] alu_b,
  output logic [2:0]            alu_ctrl,
  output logic                  alu_sel,
  input  logic [PAR*LANE_W-1:0] alu_result,
  input  logic [PAR*4-1:0]      alu_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [255:0]          out_result,
  output logic [63:0]           out_flags,
  output logic                  busy
);

  localparam int PW = PAR * LANE_W;
  localparam int FW = PAR * 4;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]              beat;
  logic [BEATS-1:0][PW-1:0]   a_q;
  logic [BEATS-1:0][PW-1:0]   b_q;
  logic [BEATS-1:0][PW-1:0]   res_q;
  logic [BEATS-1:0][FW-1:0]   flg_q;
  logic [2:0]                 ctrl_q;
  logic                       sel_q;
  logic                       acc;
  logic                       last;

  assign last = (beat == CW'(BEATS - 1));
  assign acc  = in_valid & in_ready;

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    unique case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) state_d = EXEC;
      end
      EXEC: begin
        busy  = 1'b1;
        alu_a = a_q[beat];
        alu_b = b_q[beat];
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      sel_q  <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      if (acc) begin
        a_q    <= in_a;
        b_q    <= in_b;
        ctrl_q <= in_ctrl;
        sel_q  <= in_sel;
        beat   <= '0;
      end
      if (state == EXEC) begin
        res_q[beat] <= alu_result;
        flg_q[beat] <= alu_flags;
        beat        <= last ? '0 : beat + CW'(1);
      end
    end
  end

  assign alu_ctrl   = ctrl_q;
  assign alu_sel    = sel_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer: directed checks on PAR=4, PAR=16 and PAR=1 builds
// with a bench lane-add ALU whose flags carry the global lane index.
module tb_vector_alu_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] ia, ib;
  logic [2:0]   ictl;
  logic         isel;

  logic         iv[3];
  logic         ordy[3];
  logic         ir[3];
  logic         ov[3];
  logic         bsy[3];
  logic [255:0] ores[3];
  logic [63:0]  oflg[3];
  logic [2:0]   actl[3];
  logic         asel[3];
  logic [255:0] aaw[3];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int P = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    logic [P*16-1:0] aa, bb, rr;
    logic [P*4-1:0]  ff;
    int              bc = 0;
    logic            trk = 1'b0;

    vector_alu_sequencer #(.PAR(P)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv[g]),
      .in_ready   (ir[g]),
      .in_a       (ia),
      .in_b       (ib),
      .in_ctrl    (ictl),
      .in_sel     (isel),
      .alu_a      (aa),
      .alu_b      (bb),
      .alu_ctrl   (actl[g]),
      .alu_sel    (asel[g]),
      .alu_result (rr),
      .alu_flags  (ff),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_result (ores[g]),
      .out_flags  (oflg[g]),
      .busy       (bsy[g])
    );

    assign aaw[g] = 256'(aa);

    always_comb begin
      rr = '0;
      ff = '0;
      for (int j = 0; j < P; j++) begin
        rr[16*j +: 16] = aa[16*j +: 16] + bb[16*j +: 16];
        ff[4*j +: 4]   = 4'(bc * P + j);
      end
    end

    always @(posedge clk) begin
      if (!rst) begin
        trk <= 1'b0;
        bc  <= 0;
      end else if (iv[g] && ir[g]) begin
        trk <= 1'b1;
        bc  <= 0;
      end else if (trk) begin
        if (bc == 16 / P - 1) begin
          trk <= 1'b0;
          bc  <= 0;
        end else begin
          bc <= bc + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] abase, input logic [15:0] astep,
                      input logic [15:0] bval);
    for (int i = 0; i < 16; i++) begin
      ia[16*i +: 16] = abase + astep * 16'(i);
      ib[16*i +: 16] = bval;
    end
  endtask

  function automatic logic [255:0] expsum(input logic [15:0] abase,
                                          input logic [15:0] astep,
                                          input logic [15:0] bval);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[16*i +: 16] = abase + astep * 16'(i) + bval;
    return r;
  endfunction

  task automatic run_op(input int g, output int n);
    iv[g] = 1'b1;
    tick();
    iv[g] = 1'b0;
    n = 0;
    while (!ov[g] && n < 40) begin
      tick();
      n++;
    end
  endtask

  localparam logic [63:0] FLAGS = 64'hFEDCBA9876543210;

  logic [255:0] expr;
  logic [255:0] expa;
  int           n;

  initial begin
    rst  = 1'b0;
    ia   = '1;
    ib   = '1;
    ictl = 3'd7;
    isel = 1'b1;
    for (int g = 0; g < 3; g++) begin
      iv[g]   = 1'b1;
      ordy[g] = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_in_ready", 256'(ir[0]), 256'(0));
      chk("rst_out_valid", 256'(ov[0]), 256'(0));
      chk("rst_out_result", ores[0], 256'(0));
      chk("rst_busy", 256'(bsy[0]), 256'(0));
    end
    chk("rst_alu_ctrl", 256'({actl[0], asel[0]}), 256'(0));
    rst = 1'b1;
    for (int g = 0; g < 3; g++) iv[g] = 1'b0;
    #1;
    chk("rel_in_ready", 256'(ir[0]), 256'(1));

    load(16'h0000, 16'h0001, 16'h0100);
    ictl  = 3'd5;
    isel  = 1'b1;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ictl = 3'(b);
      isel = b[0];
      expa = '0;
      for (int j = 0; j < 4; j++) expa[16*j +: 16] = 16'(4 * b + j);
      chk($sformatf("alu_a_beat%0d", b), aaw[0], expa);
      chk($sformatf("ctrl_beat%0d", b), 256'({actl[0], asel[0]}),
          256'({3'd5, 1'b1}));
      chk($sformatf("busy_beat%0d", b), 256'(bsy[0]), 256'(1));
      tick();
    end
    expr = expsum(16'h0000, 16'h0001, 16'h0100);
    chk("add_out_valid", 256'(ov[0]), 256'(1));
    chk("add_result", ores[0], expr);
    chk("add_flags", 256'(oflg[0]), 256'(FLAGS));
    chk("done_alu_a_zero", aaw[0], 256'(0));

    for (int k = 0; k < 10; k++) begin
      iv[0] = k[0];
      ia    = {8{$urandom}};
      tick();
      chk($sformatf("bp_valid%0d", k), 256'(ov[0]), 256'(1));
      chk($sformatf("bp_result%0d", k), ores[0], expr);
      chk($sformatf("bp_ready%0d", k), 256'(ir[0]), 256'(0));
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("hs_idle_ready", 256'(ir[0]), 256'(1));
    chk("hs_idle_valid", 256'(ov[0]), 256'(0));
    chk("hs_idle_busy", 256'(bsy[0]), 256'(0));
    chk("hs_retain", ores[0], expr);

    load(16'h0000, 16'h0003, 16'h0010);
    run_op(0, n);
    chk("op2_latency", 256'(n), 256'(4));
    chk("op2_result", ores[0], expsum(16'h0000, 16'h0003, 16'h0010));
    chk("op2_flags", 256'(oflg[0]), 256'(FLAGS));
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;

    load(16'hA000, 16'h0001, 16'h0001);
    ictl  = 3'd2;
    isel  = 1'b1;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    chk("mid_busy", 256'(bsy[0]), 256'(1));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_ready", 256'(ir[0]), 256'(1));
    chk("mid_valid", 256'(ov[0]), 256'(0));
    chk("mid_result", ores[0], 256'(0));
    chk("mid_flags", 256'(oflg[0]), 256'(0));
    chk("mid_busy_low", 256'(bsy[0]), 256'(0));
    chk("mid_ctrl", 256'({actl[0], asel[0]}), 256'(0));

    load(16'h0200, 16'h0001, 16'h0020);
    run_op(0, n);
    chk("post_latency", 256'(n), 256'(4));
    chk("post_result", ores[0], expsum(16'h0200, 16'h0001, 16'h0020));
    chk("post_flags", 256'(oflg[0]), 256'(FLAGS));
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;

    load(16'h0000, 16'h0001, 16'h0100);
    run_op(1, n);
    chk("p16_latency", 256'(n), 256'(1));
    chk("p16_result", ores[1], expr);
    chk("p16_flags", 256'(oflg[1]), 256'(FLAGS));
    ordy[1] = 1'b1;
    tick();
    ordy[1] = 1'b0;
    chk("p16_idle", 256'(ir[1]), 256'(1));

    run_op(2, n);
    chk("p1_latency", 256'(n), 256'(16));
    chk("p1_result", ores[2], expr);
    chk("p1_flags", 256'(oflg[2]), 256'(FLAGS));
    ordy[2] = 1'b1;
    tick();
    ordy[2] = 1'b0;
    chk("p1_idle", 256'(ir[2]), 256'(1));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
